// File: rtl/usb_rx_decoder.sv
// rtl/usb_rx_decoder.sv - full-speed USB receive line decoder
// NRZI decode, SYNC hunt, bit-unstuffing, byte assembly and EOP detection on DLL strobes.
`timescale 1ns/1ps

module usb_rx_decoder (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sample_en,
  input  logic       i_dp,
  input  logic       i_dn,
  output logic       o_rx_active,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_error,
  output logic       o_eop
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_EOP  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // prev_sym holds D+ of the last data symbol, so J is 1 and K is 0
  localparam logic SYM_J = 1'b1;

  logic [1:0] state;
  logic       prev_sym;
  logic [6:0] shift_hist;
  logic [2:0] ones_cnt;
  logic [2:0] bit_cnt;
  logic       err_se0;

  logic       sym_j;
  logic       sym_se0;
  logic       sym_data;
  logic       nrzi_bit;
  logic [7:0] shift_next;

  assign sym_j      = i_dp & ~i_dn;
  assign sym_se0    = ~i_dp & ~i_dn;
  assign sym_data   = i_dp ^ i_dn;
  assign nrzi_bit   = (i_dp == prev_sym);
  // bit 0 of the 8-bit window falls out on the next shift, so only 7 bits are kept
  assign shift_next = {nrzi_bit, shift_hist};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      prev_sym    <= SYM_J;
      shift_hist  <= 7'd0;
      ones_cnt    <= 3'd0;
      bit_cnt     <= 3'd0;
      err_se0     <= 1'b0;
      o_rx_active <= 1'b0;
      o_rx_data   <= 8'h00;
      o_rx_valid  <= 1'b0;
      o_rx_error  <= 1'b0;
      o_eop       <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      o_eop      <= 1'b0;
      if (i_sample_en) begin
        case (state)
          ST_IDLE: begin
            // bit_cnt counts hunt bits (saturating) so the cleared register cannot fake a SYNC
            if (sym_data) begin
              prev_sym   <= i_dp;
              shift_hist <= shift_next[7:1];
              if (bit_cnt == 3'd7 && shift_next == 8'h80) begin
                state       <= ST_DATA;
                o_rx_active <= 1'b1;
                bit_cnt     <= 3'd0;
                ones_cnt    <= 3'd1;
              end else if (bit_cnt != 3'd7) begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_DATA: begin
            if (sym_data) begin
              prev_sym <= i_dp;
              if (ones_cnt == 3'd6) begin
                if (nrzi_bit) begin
                  o_rx_error <= 1'b1;
                  err_se0    <= 1'b0;
                  state      <= ST_ERR;
                end else begin
                  ones_cnt <= 3'd0;
                end
              end else begin
                shift_hist <= shift_next[7:1];
                bit_cnt    <= bit_cnt + 3'd1;
                ones_cnt   <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                if (bit_cnt == 3'd7) begin
                  o_rx_data  <= shift_next;
                  o_rx_valid <= 1'b1;
                end
              end
            end else if (sym_se0) begin
              state <= ST_EOP;
            end else begin
              o_rx_error <= 1'b1;
              err_se0    <= 1'b0;
              state      <= ST_ERR;
            end
          end

          ST_EOP: begin
            if (sym_j) begin
              o_eop       <= 1'b1;
              o_rx_error  <= (bit_cnt != 3'd0);
              o_rx_active <= 1'b0;
              state       <= ST_IDLE;
              prev_sym    <= SYM_J;
              bit_cnt     <= 3'd0;
              ones_cnt    <= 3'd0;
            end else if (!sym_se0) begin
              o_rx_error <= 1'b1;
              err_se0    <= 1'b0;
              state      <= ST_ERR;
            end
          end

          ST_ERR: begin
            // leave only on SE0 immediately followed by J
            if (sym_se0) begin
              err_se0 <= 1'b1;
            end else if (sym_j && err_se0) begin
              o_rx_active <= 1'b0;
              state       <= ST_IDLE;
              prev_sym    <= SYM_J;
              bit_cnt     <= 3'd0;
              ones_cnt    <= 3'd0;
              err_se0     <= 1'b0;
            end else begin
              err_se0 <= 1'b0;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
